// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader FSM state type, the word geometry and the word-to-byte address helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StDone,
    StErr
  } state_e;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned AsmCntW      = $clog2(BytesPerWord);

  // Instruction memory is byte addressed; words sit on 4-byte boundaries.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return idx << 2;
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a byte stream into 32-bit big-endian words.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   clr_i          discard any partial word
//   byte_valid_i   byte_i is consumed this cycle
//   byte_i         stream byte
//   word_valid_o   this cycle's byte completes a word (combinational)
//   word_o         completed word, first byte in [31:24]
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [AsmCntW-1:0] cnt_q, cnt_d;
  logic [23:0]        shift_q, shift_d;

  always_comb begin
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    word_valid_o = !clr_i && byte_valid_i && (cnt_q == AsmCntW'(BytesPerWord - 1));
    word_o       = {shift_q, byte_i};
    if (clr_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      // Counter wraps to 0 after the 4th byte, ready for the next word.
      cnt_d   = cnt_q + AsmCntW'(1);
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Accepts a 2-byte big-endian word count followed by 4*N program bytes, writes the assembled
// words to consecutive word addresses starting at 0, then raises core_run to release the core.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               begin a load (honoured only when idle, done or in error)
//   in_byte, in_valid   byte stream; in_ready says the byte is taken this cycle
//   wr_en/addr/data     one-cycle instruction-memory write port
//   word_count          words written in the current load
//   busy                load in progress
//   done, err           sticky completion / oversize-header flags
//   core_run            pipeline may fetch
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             core_run
);

  state_e           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             core_run_q, core_run_d;

  logic        xfer;
  logic        start_ok;
  logic        asm_valid;
  logic [31:0] asm_word;
  logic [15:0] hdr_len;
  logic        last_word;

  assign in_ready  = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData);
  assign xfer      = in_valid && in_ready;
  assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));
  assign hdr_len   = {len_q[15:8], in_byte};
  assign last_word = (word_count_q + CNT_W'(1)) == CNT_W'(len_q);

  imem_loader_byte_assembler u_asm (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (start_ok),
    .byte_valid_i (xfer && (state_q == StData)),
    .byte_i       (in_byte),
    .word_valid_o (asm_valid),
    .word_o       (asm_word)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_count_d = word_count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = done_q;
    err_d        = err_q;
    core_run_d   = core_run_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start_ok) begin
          state_d      = StLenHi;
          len_d        = '0;
          word_count_d = '0;
          done_d       = 1'b0;
          err_d        = 1'b0;
          core_run_d   = 1'b0;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_d   = {in_byte, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (xfer) begin
          len_d = hdr_len;
          if (hdr_len == 16'h0000) begin
            state_d    = StDone;
            done_d     = 1'b1;
            core_run_d = 1'b1;
          end else if (32'(hdr_len) > DEPTH) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (asm_valid) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = word_addr(32'(word_count_q));
          wr_data_d    = asm_word;
          word_count_d = word_count_q + CNT_W'(1);
          if (last_word) begin
            state_d    = StDone;
            done_d     = 1'b1;
            core_run_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      word_count_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      core_run_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_count_q <= word_count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      core_run_q   <= core_run_d;
    end
  end

  assign busy       = in_ready;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = word_count_q;
  assign done       = done_q;
  assign err        = err_q;
  assign core_run   = core_run_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        err;
  logic        core_run;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        start;
    logic        vld;
    logic [7:0]  b;
    logic [85:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[12];
  wr_t  wq[$];

  imem_loader #(
    .DEPTH (64),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .core_run   (core_run)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back('{addr: wr_addr, data: wr_data});
  end

  function automatic logic [85:0] obs();
    return {in_ready, wr_en, wr_addr, wr_data, word_count, done, err, core_run, busy};
  endfunction

  // Expected observation; busy always equals in_ready.
  function automatic logic [85:0] mk(input logic ir, input logic we, input logic [31:0] a,
                                     input logic [31:0] d, input logic [15:0] wc,
                                     input logic dn, input logic er, input logic cr);
    return {ir, we, a, d, wc, dn, er, cr, ir};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] b);
    start    = s;
    in_valid = v;
    in_byte  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int unsigned max_gap);
    repeat ($urandom_range(max_gap, 0)) step(1'b0, 1'b0, 8'h5A);
    step(1'b0, 1'b1, b);
  endtask

  initial begin
    logic [7:0]  bytes3[10];
    logic [31:0] exp_d;

    // Reset with a valid byte offered: nothing may be taken or written.
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    @(posedge clk);
    #1;
    check("reset_c1", 128'(obs()), 128'(86'd0));
    @(posedge clk);
    #1;
    check("reset_c2", 128'(obs()), 128'(86'd0));
    rst      = 1'b0;
    in_valid = 1'b0;

    // Two-word load at full rate, checked cycle by cycle.
    vecs[0]  = '{start: 1'b1, vld: 1'b0, b: 8'h00, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{start: 1'b0, vld: 1'b1, b: 8'h00, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{start: 1'b0, vld: 1'b1, b: 8'h02, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{start: 1'b0, vld: 1'b1, b: 8'h20, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{start: 1'b0, vld: 1'b1, b: 8'h08, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[5]  = '{start: 1'b0, vld: 1'b1, b: 8'h00, exp: mk(1, 0, 0, 0, 0, 0, 0, 0)};
    vecs[6]  = '{start: 1'b0, vld: 1'b1, b: 8'h05,
                 exp: mk(1, 1, 32'h0, 32'h20080005, 1, 0, 0, 0)};
    vecs[7]  = '{start: 1'b0, vld: 1'b1, b: 8'h8C,
                 exp: mk(1, 0, 32'h0, 32'h20080005, 1, 0, 0, 0)};
    vecs[8]  = '{start: 1'b0, vld: 1'b1, b: 8'h09,
                 exp: mk(1, 0, 32'h0, 32'h20080005, 1, 0, 0, 0)};
    vecs[9]  = '{start: 1'b0, vld: 1'b1, b: 8'h00,
                 exp: mk(1, 0, 32'h0, 32'h20080005, 1, 0, 0, 0)};
    vecs[10] = '{start: 1'b0, vld: 1'b1, b: 8'h04,
                 exp: mk(0, 1, 32'h4, 32'h8C090004, 2, 1, 0, 1)};
    vecs[11] = '{start: 1'b0, vld: 1'b1, b: 8'hFF,
                 exp: mk(0, 0, 32'h4, 32'h8C090004, 2, 1, 0, 1)};
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].start, vecs[i].vld, vecs[i].b);
      check($sformatf("load2_vec%0d", i), 128'(obs()), 128'(vecs[i].exp));
    end
    step(1'b0, 1'b0, 8'h00);
    wq.delete();

    // Same stream with random valid gaps.
    bytes3 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) send(bytes3[i], 3);
    check("throttle_final", 128'(obs()), 128'(mk(0, 1, 32'h4, 32'h8C090004, 2, 1, 0, 1)));
    step(1'b0, 1'b0, 8'h00);
    check("throttle_nwr", 128'(wq.size()), 128'(2));
    if (wq.size() == 2) begin
      check("throttle_wr0", 128'({wq[0].addr, wq[0].data}), 128'({32'h0, 32'h20080005}));
      check("throttle_wr1", 128'({wq[1].addr, wq[1].data}), 128'({32'h4, 32'h8C090004}));
    end
    wq.delete();

    // Oversize header, then an empty program.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h41);
    check("err_state", 128'(obs()), 128'(mk(0, 0, 32'h4, 32'h8C090004, 0, 0, 1, 0)));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h33);
    check("err_hold", 128'(obs()), 128'(mk(0, 0, 32'h4, 32'h8C090004, 0, 0, 1, 0)));
    step(1'b1, 1'b0, 8'h00);
    check("err_restart", 128'(obs()), 128'(mk(1, 0, 32'h4, 32'h8C090004, 0, 0, 0, 0)));
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("len0_done", 128'(obs()), 128'(mk(0, 0, 32'h4, 32'h8C090004, 0, 1, 0, 1)));
    step(1'b0, 1'b0, 8'h00);
    check("err_len0_nwr", 128'(wq.size()), 128'(0));
    wq.delete();

    // Reset in the middle of a 3-word load, then a fresh 1-word load.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b1, 8'h44);
    step(1'b0, 1'b1, 8'h55);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    check("midrst_state", 128'(obs()), 128'(86'd0));
    check("midrst_nwr", 128'(wq.size()), 128'(1));
    if (wq.size() >= 1)
      check("midrst_wr0", 128'({wq[0].addr, wq[0].data}), 128'({32'h0, 32'h11223344}));
    step(1'b0, 1'b1, 8'h66);
    check("midrst_idle", 128'(obs()), 128'(86'd0));
    wq.delete();
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h01);
    step(1'b0, 1'b1, 8'hAA);
    step(1'b0, 1'b1, 8'hBB);
    step(1'b0, 1'b1, 8'hCC);
    step(1'b0, 1'b1, 8'hDD);
    check("reload_done", 128'(obs()), 128'(mk(0, 1, 32'h0, 32'hAABBCCDD, 1, 1, 0, 1)));
    step(1'b0, 1'b0, 8'h00);
    check("reload_nwr", 128'(wq.size()), 128'(1));
    wq.delete();

    // Full-depth load with a start pulse in the middle of the data phase.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h40);
    for (int i = 0; i < 256; i++) begin
      step((i == 100 || i == 101), (i != 101) ? 1'b1 : 1'b0, 8'(i));
      if (i == 101) step(1'b0, 1'b1, 8'(i));
    end
    check("full_done", 128'(obs()), 128'(mk(0, 1, 32'hFC, 32'hFCFDFEFF, 64, 1, 0, 1)));
    step(1'b0, 1'b0, 8'h00);
    check("full_nwr", 128'(wq.size()), 128'(64));
    if (wq.size() == 64) begin
      for (int k = 0; k < 64; k++) begin
        exp_d = {8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)};
        check($sformatf("full_wr%0d", k), 128'({wq[k].addr, wq[k].data}),
              128'({32'(4 * k), exp_d}));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
